// File: rtl/ceespu_mem_arbiter_if.sv
// Bundled request, response and memory-side signals of the CEESPU memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters and memory.
interface ceespu_mem_arbiter_if;
  logic        I_fetchReq;
  logic [15:0] I_fetchAddress;
  logic [31:0] O_fetchData;
  logic        O_fetchValid;
  logic        O_fetchBusy;

  logic        I_dataE;
  logic [3:0]  I_dataWe;
  logic [15:0] I_dataAddress;
  logic [31:0] I_dataWData;
  logic [31:0] O_dataRData;
  logic        O_dataValid;
  logic        O_dataBusy;

  logic        O_memE;
  logic [3:0]  O_memWe;
  logic [15:0] O_memAddress;
  logic [31:0] O_memWData;
  logic [31:0] I_memData;
  logic        I_memReady;

  modport slave (
    input  I_fetchReq, I_fetchAddress,
    output O_fetchData, O_fetchValid, O_fetchBusy,
    input  I_dataE, I_dataWe, I_dataAddress, I_dataWData,
    output O_dataRData, O_dataValid, O_dataBusy,
    output O_memE, O_memWe, O_memAddress, O_memWData,
    input  I_memData, I_memReady
  );

  modport master (
    output I_fetchReq, I_fetchAddress,
    input  O_fetchData, O_fetchValid, O_fetchBusy,
    output I_dataE, I_dataWe, I_dataAddress, I_dataWData,
    input  O_dataRData, O_dataValid, O_dataBusy,
    input  O_memE, O_memWe, O_memAddress, O_memWData,
    output I_memData, I_memReady
  );
endinterface

// File: rtl/ceespu_mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-port memory with one-cycle read latency.
// Define CEESPU_ARB_STARVE_EN to add the fetch anti-starvation counter; otherwise data has strict priority.
module ceespu_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic I_clk,
  input logic I_rst,
  ceespu_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_RSP = 2'd1,
    DATA_RSP  = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   dataWrite_q, dataWrite_d;
  logic   forceFetch;
  logic   grantData;
  logic   grantFetch;
  logic   memE;
  logic   accept;
  logic   rspEnable;
  logic   unusedAddrBits;

`ifdef CEESPU_ARB_STARVE_EN
  localparam int CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starveCnt_q, starveCnt_d;

  assign forceFetch = (starveCnt_q == CntW'(STARVE_LIMIT));

  // A stalled memory freezes the count so a wait state is never mistaken for a lost conflict.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (bus.I_memReady) begin
      if (!bus.I_fetchReq || (grantFetch && accept)) begin
        starveCnt_d = '0;
      end else if (grantData && accept && !forceFetch) begin
        starveCnt_d = starveCnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  logic unusedLimit;

  assign forceFetch  = 1'b0;
  assign unusedLimit = (STARVE_LIMIT != 0);
`endif

  assign grantData  = !I_rst && bus.I_dataE && !(bus.I_fetchReq && forceFetch);
  assign grantFetch = !I_rst && bus.I_fetchReq && !grantData;
  assign memE       = !I_rst && (bus.I_fetchReq || bus.I_dataE);
  assign accept     = memE && bus.I_memReady;

  // Fetches are always word-aligned reads, so the low address bits are dropped.
  assign unusedAddrBits   = ^bus.I_fetchAddress[1:0];
  assign bus.O_memE       = memE;
  assign bus.O_memAddress = grantData ? bus.I_dataAddress : {bus.I_fetchAddress[15:2], 2'b00};
  assign bus.O_memWe      = grantData ? bus.I_dataWe : 4'b0000;
  assign bus.O_memWData   = grantData ? bus.I_dataWData : 32'h0;

  assign bus.O_fetchBusy = bus.I_fetchReq && !(grantFetch && bus.I_memReady);
  assign bus.O_dataBusy  = bus.I_dataE && !(grantData && bus.I_memReady);

  always_comb begin
    owner_d     = IDLE;
    dataWrite_d = 1'b0;
    if (accept) begin
      owner_d     = grantFetch ? FETCH_RSP : DATA_RSP;
      dataWrite_d = grantData && (bus.I_dataWe != 4'b0000);
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      owner_q     <= IDLE;
      dataWrite_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      dataWrite_q <= dataWrite_d;
    end
  end

  // Responses are masked during reset so an access accepted just before reset is dropped.
  assign rspEnable        = !I_rst;
  assign bus.O_fetchValid = rspEnable && (owner_q == FETCH_RSP);
  assign bus.O_dataValid  = rspEnable && (owner_q == DATA_RSP);
  assign bus.O_fetchData  = bus.O_fetchValid ? bus.I_memData : 32'h0;
  assign bus.O_dataRData  = (bus.O_dataValid && !dataWrite_q) ? bus.I_memData : 32'h0;

endmodule
